// File: rtl/via_pkg.sv
// Shared encodings for the VIA timer bank: channel modes, register map offsets,
// CTRL bit positions and the IER set/clear update rule.
package via_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_FREERUN = 2'b01,
    MODE_PULSE   = 2'b10,
    MODE_OFF     = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_WRAPPED = 2'b10
  } ch_state_e;

  localparam int         CH_STRIDE   = 8;
  localparam logic [2:0] OFF_CTRL    = 3'd4;
  localparam int         CTRL_OUT_EN = 2;
  localparam int         CTRL_ARMED  = 7;
  localparam int         REG_IFR     = 0;
  localparam int         REG_IER     = 1;

  // Bit 7 selects set (1) or clear (0) of the 1-bits in [6:0].
  function automatic logic [6:0] ier_next(input logic [6:0] ier, input logic [7:0] wdata);
    return wdata[7] ? (ier | wdata[6:0]) : (ier & ~wdata[6:0]);
  endfunction

endpackage

// File: rtl/via_timer_ch.sv
// One timer channel: latch, down-counter, coherent-read hold register,
// cnt_in synchronizer/edge detect, IDLE/ARMED/WRAPPED state and timer output.
module via_timer_ch
  import via_pkg::*;
#(
  parameter int TIMER_W = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       wr,
  input  logic       rd,
  input  logic [2:0] off,
  input  logic [7:0] wdata,
  input  logic       cnt_in,
  output logic [7:0] rdata,
  output logic       flag_set,
  output logic       flag_clr,
  output logic       tmr_out
);

  localparam int BYTES = TIMER_W / 8;
  localparam logic [TIMER_W-1:0] ONE = TIMER_W'(1);

  logic [TIMER_W-1:0] count, latch, hold, load_val;
  mode_e              mode;
  logic               out_en;
  ch_state_e          state;
  logic               sync_p0, sync_p1, sync_p2;
  logic               tick, underflow, load;

  assign load      = wr && (int'(off) == BYTES - 1);
  assign underflow = tick && (count == '0);
  // A load in the same cycle as an underflow suppresses the flag.
  assign flag_set  = underflow && !load && (mode == MODE_FREERUN || state == ST_ARMED);
  assign flag_clr  = load || (rd && off == 3'd0);

  always_comb begin
    tick = 1'b0;
    unique case (mode)
      MODE_ONESHOT, MODE_FREERUN: tick = 1'b1;
      MODE_PULSE:                 tick = sync_p1 & ~sync_p2;
      default:                    tick = 1'b0;
    endcase
  end

  always_comb begin
    load_val = latch;
    load_val[TIMER_W-1 -: 8] = wdata;
  end

  always_comb begin
    rdata = 8'h00;
    for (int k = 0; k < BYTES; k++)
      if (int'(off) == k) rdata = (k == 0) ? count[7:0] : hold[8*k +: 8];
    if (off == OFF_CTRL) begin
      rdata[1:0]         = mode;
      rdata[CTRL_OUT_EN] = out_en;
      rdata[CTRL_ARMED]  = (state == ST_ARMED);
    end
  end

  // cnt_in stages: two-flop synchronizer (p0, p1) then edge-detect history (p2)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= cnt_in;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      latch   <= '0;
      hold    <= '0;
      mode    <= MODE_ONESHOT;
      out_en  <= 1'b0;
      state   <= ST_IDLE;
      tmr_out <= 1'b1;
    end else begin
      for (int k = 0; k < BYTES; k++)
        if (wr && int'(off) == k) latch[8*k +: 8] <= wdata;
      if (wr && off == OFF_CTRL) begin
        mode   <= mode_e'(wdata[1:0]);
        out_en <= wdata[CTRL_OUT_EN];
      end
      if (rd && off == 3'd0) hold <= count;

      if (load) count <= load_val;
      else if (tick) begin
        if (count != '0)             count <= count - ONE;
        else if (mode == MODE_FREERUN) count <= latch;
        else                         count <= '1;
      end

      if (load) begin
        state <= ST_ARMED;
        if (mode == MODE_ONESHOT && out_en) tmr_out <= 1'b0;
      end else if (underflow) begin
        if (mode == MODE_FREERUN) begin
          if (out_en) tmr_out <= ~tmr_out;
        end else if (state == ST_ARMED) begin
          state   <= ST_WRAPPED;
          tmr_out <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/via_timer_bank.sv
// Bank of NUM_CH VIA-style timers behind an 8-bit register bus, with shared
// IFR/IER interrupt registers, registered read data and a registered irq.
module via_timer_bank
  import via_pkg::*;
#(
  parameter int NUM_CH  = 4,
  parameter int TIMER_W = 16,
  parameter int ADDR_W  = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        dataIn,
  output logic [7:0]        dataOut,
  input  logic [NUM_CH-1:0] cnt_in,
  output logic [NUM_CH-1:0] tmr_out,
  output logic              irq
);

  localparam int         REG_BASE = NUM_CH * CH_STRIDE;
  localparam logic [6:0] CH_MASK  = 7'((1 << NUM_CH) - 1);

  logic                   bus_wr, bus_rd, ifr_sel, ier_sel, pending;
  logic [6:0]             ifr, ier, ifr_wclr;
  logic [NUM_CH-1:0]      flag_set, flag_clr;
  logic [NUM_CH-1:0][7:0] ch_rdata;
  logic [7:0]             rd_mux;

  assign bus_wr   = cs && !rw;
  assign bus_rd   = cs && rw;
  assign ifr_sel  = (int'(addr) == REG_BASE + REG_IFR);
  assign ier_sel  = (int'(addr) == REG_BASE + REG_IER);
  assign pending  = |(ifr & ier);
  assign ifr_wclr = (bus_wr && ifr_sel) ? dataIn[6:0] : 7'h00;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = (int'(addr[ADDR_W-1:3]) == c);

    via_timer_ch #(.TIMER_W(TIMER_W)) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr       (bus_wr && sel),
      .rd       (bus_rd && sel),
      .off      (addr[2:0]),
      .wdata    (dataIn),
      .cnt_in   (cnt_in[c]),
      .rdata    (ch_rdata[c]),
      .flag_set (flag_set[c]),
      .flag_clr (flag_clr[c]),
      .tmr_out  (tmr_out[c])
    );
  end

  always_comb begin
    rd_mux = 8'h00;
    for (int c = 0; c < NUM_CH; c++)
      if (int'(addr[ADDR_W-1:3]) == c) rd_mux = ch_rdata[c];
    if (ifr_sel) rd_mux = {pending, ifr};
    if (ier_sel) rd_mux = {1'b1, ier};
  end

  // Flag sets win over any clear arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ifr     <= 7'h00;
      ier     <= 7'h00;
      irq     <= 1'b0;
      dataOut <= 8'h00;
    end else begin
      ifr <= ((ifr & ~(7'(flag_clr) | ifr_wclr)) | 7'(flag_set)) & CH_MASK;
      if (bus_wr && ier_sel) ier <= ier_next(ier, dataIn) & CH_MASK;
      irq <= pending;
      if (bus_rd) dataOut <= rd_mux;
    end
  end

endmodule

// File: tb/tb_via_timer_bank.sv
// Directed bench for via_timer_bank: free-run, one-shot, interrupts, coherent
// reads, pulse counting, flag collisions and asynchronous reset.
module tb_via_timer_bank;

  localparam logic [5:0] A_IFR = 6'd32;
  localparam logic [5:0] A_IER = 6'd33;

  logic       clk = 1'b0;
  logic       reset_n, cs, rw, irq;
  logic [5:0] addr;
  logic [7:0] dataIn, dataOut;
  logic [3:0] cnt_in, tmr_out;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  via_timer_bank #(.NUM_CH(4), .TIMER_W(16), .ADDR_W(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .cs      (cs),
    .rw      (rw),
    .addr    (addr),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .cnt_in  (cnt_in),
    .tmr_out (tmr_out),
    .irq     (irq)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bus tasks start at a falling edge; the access is sampled on the next rising edge.
  task automatic bus_wr(input logic [5:0] a, input logic [7:0] d);
    cs = 1'b1; rw = 1'b0; addr = a; dataIn = d;
    @(negedge clk);
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [7:0] d);
    cs = 1'b1; rw = 1'b1; addr = a;
    @(negedge clk);
    cs = 1'b0;
    d = dataOut;
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a, input logic [7:0] exp);
    logic [7:0] v;
    bus_rd(a, v);
    check_eq(tag, {24'h0, v}, {24'h0, exp});
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cs = 1'b0; rw = 1'b1; addr = '0; dataIn = '0; cnt_in = '0; reset_n = 1'b0;
    idle(3);
    check_eq("rst_tmr_out", tmr_out, 4'hF);
    check_eq("rst_irq", irq, 0);
    check_eq("rst_dout", dataOut, 0);
    reset_n = 1'b1;
    rd_chk("rst_ifr", A_IFR, 8'h00);
    rd_chk("rst_ier", A_IER, 8'h80);
    rd_chk("rst_ctrl0", 6'd4, 8'h00);

    // Free-run ch0, latch 9: flag every 10 clks, output period 20 clks
    bus_wr(6'd4, 8'h05);
    bus_wr(6'd0, 8'h09);
    bus_wr(6'd1, 8'h00);
    check_eq("fr_out_p0", tmr_out[0], 1);
    idle(9);
    check_eq("fr_out_p9", tmr_out[0], 1);
    idle(1);
    check_eq("fr_out_p10", tmr_out[0], 0);
    rd_chk("fr_ifr_p11", A_IFR, 8'h01);
    bus_wr(A_IFR, 8'h01);
    rd_chk("fr_ifr_clr", A_IFR, 8'h00);
    idle(6);
    check_eq("fr_out_p19", tmr_out[0], 0);
    idle(1);
    check_eq("fr_out_p20", tmr_out[0], 1);
    rd_chk("fr_ifr_p21", A_IFR, 8'h01);
    idle(8);
    bus_wr(A_IFR, 8'h01);
    rd_chk("coll_ifr", A_IFR, 8'h01);
    bus_wr(6'd4, 8'h07);
    bus_wr(A_IFR, 8'h01);
    rd_chk("off_ifr", A_IFR, 8'h00);

    // One-shot ch1, latch 3
    bus_wr(6'd12, 8'h04);
    bus_wr(6'd8, 8'h03);
    bus_wr(6'd9, 8'h00);
    check_eq("os_out_q0", tmr_out[1], 0);
    rd_chk("os_armed", 6'd12, 8'h84);
    idle(2);
    check_eq("os_out_q3", tmr_out[1], 0);
    idle(1);
    check_eq("os_out_q4", tmr_out[1], 1);
    rd_chk("os_ifr", A_IFR, 8'h02);
    bus_wr(A_IER, 8'h82);
    check_eq("irq_q6", irq, 0);
    idle(1);
    check_eq("irq_q7", irq, 1);
    rd_chk("ifr_bit7", A_IFR, 8'h82);
    bus_wr(A_IFR, 8'h02);
    idle(1);
    check_eq("irq_clr", irq, 0);
    bus_wr(A_IER, 8'h02);
    rd_chk("ier_clr", A_IER, 8'h80);
    rd_chk("os_cnt_lo", 6'd8, 8'hF7);
    rd_chk("os_cnt_hi", 6'd9, 8'hFF);
    rd_chk("os_cnt_lo2", 6'd8, 8'hF5);
    rd_chk("os_disarmed", 6'd12, 8'h04);
    rd_chk("os_no_reflag", A_IFR, 8'h00);

    // Coherent read ch2, free-run latch 0x0100
    bus_wr(6'd20, 8'h01);
    bus_wr(6'd16, 8'h00);
    bus_wr(6'd17, 8'h01);
    rd_chk("coh_lo", 6'd16, 8'h00);
    rd_chk("coh_hi", 6'd17, 8'h01);
    rd_chk("rsvd_b2", 6'd18, 8'h00);
    bus_wr(6'd18, 8'h55);
    rd_chk("rsvd_b2w", 6'd18, 8'h00);
    rd_chk("rsvd_b5", 6'd21, 8'h00);
    rd_chk("bad_addr", 6'd34, 8'h00);
    idle(251);
    rd_chk("ch2_ifr", A_IFR, 8'h04);
    rd_chk("ch2_cnt_lo", 6'd16, 8'hFE);
    rd_chk("ch2_rdclr", A_IFR, 8'h00);
    bus_wr(6'd20, 8'h7B);
    rd_chk("ctrl_rsvd", 6'd20, 8'h83);

    // Pulse-count ch3, latch 2, three 4-clk pulses
    bus_wr(6'd28, 8'h02);
    bus_wr(6'd24, 8'h02);
    bus_wr(6'd25, 8'h00);
    for (int p = 0; p < 2; p++) begin
      cnt_in[3] = 1'b1;
      idle(4);
      cnt_in[3] = 1'b0;
      idle(4);
    end
    rd_chk("pc_ifr0", A_IFR, 8'h00);
    rd_chk("pc_cnt", 6'd24, 8'h00);
    cnt_in[3] = 1'b1;
    idle(2);
    rd_chk("pc_ifr_e3", A_IFR, 8'h00);
    rd_chk("pc_ifr_e4", A_IFR, 8'h08);
    cnt_in[3] = 1'b0;

    // Asynchronous reset mid-count
    bus_wr(A_IER, 8'h88);
    idle(1);
    check_eq("irq_pre_rst", irq, 1);
    #3 reset_n = 1'b0;
    #1;
    check_eq("arst_tmr_out", tmr_out, 4'hF);
    check_eq("arst_irq", irq, 0);
    check_eq("arst_dout", dataOut, 0);
    @(negedge clk);
    reset_n = 1'b1;
    rd_chk("prst_cnt_lo", 6'd0, 8'h00);
    rd_chk("prst_cnt_hi", 6'd1, 8'h00);
    rd_chk("prst_ifr", A_IFR, 8'h00);
    rd_chk("prst_ier", A_IER, 8'h80);
    rd_chk("prst_ctrl2", 6'd20, 8'h00);
    check_eq("prst_irq", irq, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
